// File: rtl/reg_bank_arbiter.sv
// Config/status register bank shared by two req/gnt/rvalid requesters.
// Round-robin arbitration, one access in flight: IDLE -> ACCESS -> RESP.
module reg_bank_arbiter #(
  parameter int                   NUM_CFG    = 8,
  parameter int                   NUM_STATUS = 8,
  parameter int                   REG_WIDTH  = 8,
  parameter int                   ADDR_W     = 4,
  parameter logic [REG_WIDTH-1:0] CFG_RESET  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic                             a_req,
  input  logic                             a_we,
  input  logic [ADDR_W-1:0]                a_addr,
  input  logic [REG_WIDTH-1:0]             a_wdata,
  output logic                             a_gnt,
  output logic                             a_rvalid,
  output logic [REG_WIDTH-1:0]             a_rdata,
  output logic                             a_err,
  input  logic                             b_req,
  input  logic                             b_we,
  input  logic [ADDR_W-1:0]                b_addr,
  input  logic [REG_WIDTH-1:0]             b_wdata,
  output logic                             b_gnt,
  output logic                             b_rvalid,
  output logic [REG_WIDTH-1:0]             b_rdata,
  output logic                             b_err,
  input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
  output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
  output logic                             busy
);
  localparam int CIDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int SIDX_W = (NUM_STATUS > 1) ? $clog2(NUM_STATUS) : 1;
  localparam logic [ADDR_W:0] CFG_END = (ADDR_W+1)'(NUM_CFG);
  localparam logic [ADDR_W:0] MAP_END = (ADDR_W+1)'(NUM_CFG + NUM_STATUS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                              state_q, state_d;
  logic                                last_b_q, last_b_d;
  logic                                win_b_q, win_b_d;
  logic                                we_q, we_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [REG_WIDTH-1:0]                wdata_q, wdata_d;
  logic [NUM_CFG-1:0][REG_WIDTH-1:0]   cfg_q, cfg_d;
  logic                                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                                a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [REG_WIDTH-1:0]                a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                                a_err_q, a_err_d, b_err_q, b_err_d;

  logic [NUM_STATUS-1:0][REG_WIDTH-1:0] stat_w;
  logic [SIDX_W-1:0]                   stat_off;
  logic                                is_cfg, is_stat, pick_b, op_err;
  logic [REG_WIDTH-1:0]                op_rdata;

  assign stat_w   = status_regs;
  assign is_cfg   = {1'b0, addr_q} < CFG_END;
  assign is_stat  = !is_cfg && ({1'b0, addr_q} < MAP_END);
  assign stat_off = SIDX_W'(addr_q - CFG_END[ADDR_W-1:0]);
  // B wins only if A is idle or A was the most recent winner.
  assign pick_b   = b_req && (!a_req || !last_b_q);

  always_comb begin
    op_rdata = '0;
    op_err   = 1'b0;
    if (is_cfg)
      op_rdata = we_q ? wdata_q : cfg_q[addr_q[CIDX_W-1:0]];
    else if (is_stat && !we_q)
      op_rdata = stat_w[stat_off];
    else
      op_err = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    win_b_d    = win_b_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cfg_d      = cfg_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    a_err_d    = a_err_q;
    b_rdata_d  = b_rdata_q;
    b_err_d    = b_err_q;
    case (state_q)
      IDLE: if (a_req || b_req) begin
        win_b_d  = pick_b;
        last_b_d = pick_b;
        we_d     = pick_b ? b_we    : a_we;
        addr_d   = pick_b ? b_addr  : a_addr;
        wdata_d  = pick_b ? b_wdata : a_wdata;
        a_gnt_d  = !pick_b;
        b_gnt_d  = pick_b;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (we_q && is_cfg) cfg_d[addr_q[CIDX_W-1:0]] = wdata_q;
        if (win_b_q) begin
          b_rdata_d  = op_rdata;
          b_err_d    = op_err;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = op_rdata;
          a_err_d    = op_err;
          a_rvalid_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      win_b_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cfg_q      <= {NUM_CFG{CFG_RESET}};
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      a_err_q    <= 1'b0;
      b_rdata_q  <= '0;
      b_err_q    <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      win_b_q    <= win_b_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cfg_q      <= cfg_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      a_err_q    <= a_err_d;
      b_rdata_q  <= b_rdata_d;
      b_err_q    <= b_err_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign a_err       = a_err_q;
  assign b_err       = b_err_q;
  assign config_regs = cfg_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor pops and compares.
module tb_reg_bank_arbiter;
  localparam int NC = 8, NS = 6, W = 8, AW = 4;

  logic clk = 1'b0;
  logic rst, ena;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, busy;
  logic [NS*W-1:0] status_regs;
  logic [NC*W-1:0] config_regs;

  typedef struct { logic [W-1:0] rdata; logic err; } resp_t;
  resp_t qa[$], qb[$];
  bit glog[$];
  logic [W-1:0] m_cfg[NC];
  logic [W-1:0] m_stat[NS];
  bit mlast;
  int nvec = 0, nerr = 0;

  reg_bank_arbiter #(.NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(W), .ADDR_W(AW),
                     .CFG_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .status_regs(status_regs), .config_regs(config_regs), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic set_status();
    for (int i = 0; i < NS; i++) status_regs[i*W +: W] = m_stat[i];
  endtask

  // Reference behaviour of one committed access against the address map.
  function automatic resp_t model(input bit we, input logic [AW-1:0] ad, input logic [W-1:0] wd);
    resp_t r;
    int ai = int'(ad);
    r.rdata = '0;
    r.err   = 1'b0;
    if (ai < NC) begin
      if (we) begin m_cfg[ai] = wd; r.rdata = wd; end
      else r.rdata = m_cfg[ai];
    end else if (ai < NC + NS && !we) r.rdata = m_stat[ai - NC];
    else r.err = 1'b1;
    return r;
  endfunction

  task automatic do_acc(input bit p, input bit we, input logic [AW-1:0] ad, input logic [W-1:0] wd);
    int t = 0;
    if (!p) begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
    else    begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
    do begin @(negedge clk); t++; end while (!(p ? b_gnt : a_gnt) && t < 100);
    if (!(p ? b_gnt : a_gnt)) begin
      fail_now(p ? "b_gnt_wait" : "a_gnt_wait");
      if (!p) a_req = 1'b0; else b_req = 1'b0;
      return;
    end
    if (!p) qa.push_back(model(we, ad, wd)); else qb.push_back(model(we, ad, wd));
    mlast = p;
    @(posedge clk); #1;
    if (!p) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin @(posedge clk); t++; end
    if (t >= 100) begin fail_now("resp_wait"); qa.delete(); qb.delete(); end
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  initial begin : monitor
    bit pa_g, pb_g, pa_v, pb_v;
    resp_t e;
    pa_g = 0; pb_g = 0; pa_v = 0; pb_v = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa_g = 0; pb_g = 0; pa_v = 0; pb_v = 0;
      end else begin
        chk("gnt_excl", a_gnt & b_gnt, 0);
        chk("rvalid_excl", a_rvalid & b_rvalid, 0);
        if (a_gnt && !pa_g) glog.push_back(1'b0);
        if (b_gnt && !pb_g) glog.push_back(1'b1);
        if (a_rvalid && !pa_v) begin
          if (qa.size() == 0) begin nvec++; nerr++; $display("FAIL a_rvalid_unexp: got 1 expected 0"); end
          else begin e = qa.pop_front(); chk("a_rdata", a_rdata, e.rdata); chk("a_err", a_err, e.err); end
        end
        if (b_rvalid && !pb_v) begin
          if (qb.size() == 0) begin nvec++; nerr++; $display("FAIL b_rvalid_unexp: got 1 expected 0"); end
          else begin e = qb.pop_front(); chk("b_rdata", b_rdata, e.rdata); chk("b_err", b_err, e.err); end
        end
        pa_g = a_gnt; pb_g = b_gnt; pa_v = a_rvalid; pb_v = b_rvalid;
      end
    end
  end

  initial begin
    bit f;
    int t;
    rst = 1'b1; ena = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < NC; i++) m_cfg[i] = '0;
    m_stat[0] = 8'hCA;
    for (int i = 1; i < NS; i++) m_stat[i] = W'($urandom);
    set_status();
    mlast = 1'b1;

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_err", {a_err, b_err}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    chk("rst_cfg", config_regs, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 16; i++) begin do_acc(0, 0, AW'(i), '0); wait_idle(); end

    // Write latency and config visibility around the ACCESS edge.
    @(posedge clk); #1;
    a_we = 1; a_addr = 4'd3; a_wdata = 8'h5A; a_req = 1;
    @(negedge clk); chk("lat_gnt_early", a_gnt, 0);
    @(negedge clk); chk("lat_gnt", a_gnt, 1);
    chk("lat_cfg_old", config_regs[31:24], m_cfg[3]);
    qa.push_back(model(1, 4'd3, 8'h5A)); mlast = 0;
    @(posedge clk); #1 a_req = 0;
    @(negedge clk);
    chk("lat_rvalid", a_rvalid, 1);
    chk("lat_gnt_off", a_gnt, 0);
    chk("lat_cfg_new", config_regs[31:24], 8'h5A);
    wait_idle();
    do_acc(1, 0, 4'd3, '0); wait_idle();

    glog.delete();
    f = !mlast;
    fork
      begin do_acc(0, 1, 4'd1, 8'h11); do_acc(0, 0, 4'd1, '0); end
      begin do_acc(1, 1, 4'd2, 8'h22); do_acc(1, 0, 4'd2, '0); end
    join
    wait_idle();
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < glog.size()) chk("rr_order", glog[i], f ^ i[0]);

    do_acc(1, 1, 4'd9, 8'h77); wait_idle();
    do_acc(1, 0, 4'd9, '0);    wait_idle();
    do_acc(1, 0, 4'd15, '0);   wait_idle();

    // Clock-enable stall while in ACCESS.
    a_we = 0; a_addr = 4'd3; a_req = 1; t = 0;
    do begin @(negedge clk); t++; end while (!a_gnt && t < 50);
    if (!a_gnt) begin fail_now("ena_gnt_wait"); a_req = 0; end
    else begin
      qa.push_back(model(0, 4'd3, '0)); mlast = 0;
      #1 ena = 0; a_req = 0;
      repeat (5) begin
        @(negedge clk);
        chk("ena_rvalid", a_rvalid, 0);
        chk("ena_busy", busy, 1);
      end
      ena = 1;
      wait_idle();
    end

    for (int i = 0; i < NS; i++) m_stat[i] = W'($urandom);
    set_status();
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk); #1;
        do_acc(0, 1'($urandom), AW'($urandom), W'($urandom));
      end
      for (int j = 0; j < 20; j++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk); #1;
        do_acc(1, 1'($urandom), AW'($urandom), W'($urandom));
      end
    join
    wait_idle();
    for (int i = 0; i < NC; i++) chk("cfg_final", config_regs[i*W +: W], m_cfg[i]);

    // Reset in the middle of an A write.
    do_acc(0, 1, 4'd0, 8'h3C); wait_idle();
    a_we = 1; a_addr = 4'd0; a_wdata = 8'hFF; a_req = 1; t = 0;
    do begin @(negedge clk); t++; end while (!a_gnt && t < 50);
    if (!a_gnt) fail_now("rst_gnt_wait");
    #1 rst = 1; a_req = 0;
    #1;
    chk("rstmid_cfg0", config_regs[7:0], 8'h00);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rvalid", a_rvalid, 0);
    for (int i = 0; i < NC; i++) m_cfg[i] = '0;
    mlast = 1'b1;
    @(posedge clk); @(negedge clk) rst = 0;
    @(negedge clk); chk("rstmid_rvalid2", a_rvalid, 0);
    glog.delete();
    fork
      do_acc(0, 1, 4'd1, 8'h11);
      do_acc(1, 1, 4'd2, 8'h22);
    join
    wait_idle();
    chk("rstmid_rr_count", glog.size(), 2);
    if (glog.size() > 0) chk("rstmid_rr_first", glog[0], 0);
    for (int i = 0; i < NC; i++) chk("cfg_after_rst", config_regs[i*W +: W], m_cfg[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
